// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding and frame geometry for the frame-buffer bank controller
package fb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, PENDING = 2'd3} fb_state_t;
  localparam int WIDTH_IMAGE  = 640;
  localparam int HEIGHT_IMAGE = 480;
  localparam int NUM_PIXELS   = WIDTH_IMAGE * HEIGHT_IMAGE;
  localparam int ADDR_WIDTH   = 19;
  localparam int DATA_WIDTH   = 24;
  localparam int CNT_WIDTH    = 16;
endpackage

// File: rtl/fb_bank_controller_if.sv
// fb_bank_controller_if: writer, display and RAM-side signals of the bank controller
interface fb_bank_controller_if #(
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = fb_pkg::CNT_WIDTH
);
  logic                  i_capture_en;
  logic                  i_frame_start;
  logic                  i_wr_enable;
  logic [ADDR_WIDTH-1:0] i_wr_address;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_disp_frame_end;
  logic                  o_ram_wr_enable;
  logic [ADDR_WIDTH:0]   o_ram_wr_address;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic                  o_rd_bank;
  logic                  o_frame_done;
  logic [CNT_WIDTH-1:0]  o_frame_count;
  logic                  o_overrun;
  logic                  o_sync_error;
  logic [1:0]            o_state;
  modport slave (
    input  i_capture_en, i_frame_start, i_wr_enable, i_wr_address, i_wr_data, i_disp_frame_end,
    output o_ram_wr_enable, o_ram_wr_address, o_ram_wr_data, o_rd_bank, o_frame_done,
           o_frame_count, o_overrun, o_sync_error, o_state
  );
  modport master (
    output i_capture_en, i_frame_start, i_wr_enable, i_wr_address, i_wr_data, i_disp_frame_end,
    input  o_ram_wr_enable, o_ram_wr_address, o_ram_wr_data, o_rd_bank, o_frame_done,
           o_frame_count, o_overrun, o_sync_error, o_state
  );
endinterface

// File: rtl/fb_write_stage.sv
// fb_write_stage: range-gated, one-cycle registered pixel write path tagged with the back-bank bit
module fb_write_stage #(
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_capture,
  input  logic                  i_wr_enable,
  input  logic [ADDR_WIDTH-1:0] i_wr_address,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_bank,
  output logic                  o_accept,
  output logic                  o_last,
  output logic                  o_ram_wr_enable,
  output logic [ADDR_WIDTH:0]   o_ram_wr_address,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_PIXELS - 1);
  assign o_accept = i_capture && i_wr_enable && (i_wr_address <= LAST);
  assign o_last   = o_accept && (i_wr_address == LAST);
  // address/data hold on rejected cycles so the RAM bus only moves on real writes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ram_wr_enable  <= 1'b0;
      o_ram_wr_address <= '0;
      o_ram_wr_data    <= '0;
    end else begin
      o_ram_wr_enable <= o_accept;
      if (o_accept) begin
        o_ram_wr_address <= {i_bank, i_wr_address};
        o_ram_wr_data    <= i_wr_data;
      end
    end
  end
endmodule

// File: rtl/fb_bank_controller.sv
// fb_bank_controller: double-buffer sequencer swapping capture/display banks in vertical blanking
module fb_bank_controller #(
  parameter int ADDR_WIDTH = fb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS,
  parameter int CNT_WIDTH  = fb_pkg::CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fb_bank_controller_if.slave  bus
);
  import fb_pkg::*;
  fb_state_t            r_state, w_next;
  logic                 r_rd_bank, r_frame_done, r_overrun, r_sync_error;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic                 w_accept, w_last, w_swap, w_overrun, w_sync_error;
  fb_write_stage #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_PIXELS(NUM_PIXELS)) u_wr (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_capture        (r_state == CAPTURE),
    .i_wr_enable      (bus.i_wr_enable),
    .i_wr_address     (bus.i_wr_address),
    .i_wr_data        (bus.i_wr_data),
    .i_bank           (~r_rd_bank),
    .o_accept         (w_accept),
    .o_last           (w_last),
    .o_ram_wr_enable  (bus.o_ram_wr_enable),
    .o_ram_wr_address (bus.o_ram_wr_address),
    .o_ram_wr_data    (bus.o_ram_wr_data)
  );
  // a frame start in CAPTURE restarts the frame, so it overrides a coincident last write
  always_comb begin
    w_next       = r_state;
    w_swap       = 1'b0;
    w_overrun    = 1'b0;
    w_sync_error = 1'b0;
    case (r_state)
      IDLE:    w_next = bus.i_capture_en ? ARMED : IDLE;
      ARMED:   w_next = !bus.i_capture_en ? IDLE : bus.i_frame_start ? CAPTURE : ARMED;
      CAPTURE: begin
        w_sync_error = bus.i_frame_start;
        w_swap       = !bus.i_frame_start && w_last && bus.i_disp_frame_end;
        if (!bus.i_frame_start && w_last)
          w_next = !bus.i_disp_frame_end ? PENDING : bus.i_capture_en ? ARMED : IDLE;
      end
      PENDING: begin
        w_swap    = bus.i_disp_frame_end;
        w_overrun = bus.i_frame_start && !bus.i_disp_frame_end;
        if (bus.i_disp_frame_end)
          w_next = !bus.i_capture_en ? IDLE : bus.i_frame_start ? CAPTURE : ARMED;
      end
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_rd_bank     <= 1'b0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_sync_error  <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rd_bank     <= r_rd_bank ^ w_swap;
      r_frame_count <= r_frame_count + CNT_WIDTH'(w_swap);
      r_frame_done  <= w_swap;
      r_overrun     <= w_overrun;
      r_sync_error  <= w_sync_error;
    end
  end
  assign bus.o_rd_bank     = r_rd_bank;
  assign bus.o_frame_count = r_frame_count;
  assign bus.o_frame_done  = r_frame_done;
  assign bus.o_overrun     = r_overrun;
  assign bus.o_sync_error  = r_sync_error;
  assign bus.o_state       = r_state;
  // accept is consumed by the write stage; unused here beyond documenting intent
  logic w_unused;
  assign w_unused = w_accept;
endmodule

// File: tb/tb_fb_bank_controller.sv
// tb_fb_bank_controller: directed self-checking bench for fb_bank_controller on a 16-pixel frame
module tb_fb_bank_controller;
  localparam int NP = 16;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  fb_bank_controller_if #(.ADDR_WIDTH(19), .DATA_WIDTH(24), .CNT_WIDTH(2)) bus ();
  fb_bank_controller #(.ADDR_WIDTH(19), .DATA_WIDTH(24), .NUM_PIXELS(NP), .CNT_WIDTH(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [23:0] pix(input int a);
    return 24'(a * 7 + 24'h100);
  endfunction
  task automatic wr(input int a);
    bus.i_wr_enable  = 1'b1;
    bus.i_wr_address = 19'(a);
    bus.i_wr_data    = pix(a);
    cyc();
  endtask
  task automatic chk_wr(input int a, input logic bank);
    chk("ram_en", 32'(bus.o_ram_wr_enable), 32'd1);
    chk("ram_addr", 32'(bus.o_ram_wr_address), 32'({bank, 19'(a)}));
    chk("ram_data", 32'(bus.o_ram_wr_data), 32'(pix(a)));
  endtask
  task automatic frame(input int from, input logic bank);
    for (int a = from; a < NP; a++) begin
      wr(a);
      chk_wr(a, bank);
    end
    bus.i_wr_enable = 1'b0;
    chk("state_pending", 32'(bus.o_state), 32'd3);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_capture_en = 0; bus.i_frame_start = 0; bus.i_wr_enable = 0;
    bus.i_wr_address = '0; bus.i_wr_data = '0; bus.i_disp_frame_end = 0;
    cyc(); cyc();
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    chk("rst_count", 32'(bus.o_frame_count), 32'd0);
    chk("rst_ram_en", 32'(bus.o_ram_wr_enable), 32'd0);
    chk("rst_ram_addr", 32'(bus.o_ram_wr_address), 32'd0);
    chk("rst_ram_data", 32'(bus.o_ram_wr_data), 32'd0);
    chk("rst_done", 32'(bus.o_frame_done), 32'd0);
    chk("rst_overrun", 32'(bus.o_overrun), 32'd0);
    chk("rst_sync", 32'(bus.o_sync_error), 32'd0);
    rst = 1'b0;
    // IDLE <-> ARMED on capture enable
    bus.i_capture_en = 1; cyc(); chk("armed", 32'(bus.o_state), 32'd1);
    bus.i_capture_en = 0; cyc(); chk("armed_to_idle", 32'(bus.o_state), 32'd0);
    bus.i_capture_en = 1; cyc(); chk("armed2", 32'(bus.o_state), 32'd1);
    // full frame into bank 1, swap on display frame end
    bus.i_frame_start = 1; cyc(); bus.i_frame_start = 0;
    chk("capture", 32'(bus.o_state), 32'd2);
    frame(0, 1'b1);
    cyc();
    chk("pend_no_write", 32'(bus.o_ram_wr_enable), 32'd0);
    chk("pend_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    bus.i_disp_frame_end = 1; cyc(); bus.i_disp_frame_end = 0;
    chk("swap1_rd_bank", 32'(bus.o_rd_bank), 32'd1);
    chk("swap1_done", 32'(bus.o_frame_done), 32'd1);
    chk("swap1_count", 32'(bus.o_frame_count), 32'd1);
    chk("swap1_state", 32'(bus.o_state), 32'd1);
    cyc();
    chk("swap1_done_clr", 32'(bus.o_frame_done), 32'd0);
    // out-of-range writes dropped; display end outside PENDING ignored
    bus.i_frame_start = 1; cyc(); bus.i_frame_start = 0;
    chk("capture2", 32'(bus.o_state), 32'd2);
    bus.i_disp_frame_end = 1;
    wr(NP);     chk("oor_en_a", 32'(bus.o_ram_wr_enable), 32'd0);
    wr(307200); chk("oor_en_b", 32'(bus.o_ram_wr_enable), 32'd0);
    wr(524287); chk("oor_en_c", 32'(bus.o_ram_wr_enable), 32'd0);
    bus.i_disp_frame_end = 0;
    chk("oor_addr_hold", 32'(bus.o_ram_wr_address), 32'h8000F);
    chk("oor_rd_bank", 32'(bus.o_rd_bank), 32'd1);
    chk("oor_state", 32'(bus.o_state), 32'd2);
    // mid-frame restart gives a sync error, no swap
    for (int a = 0; a < 10; a++) begin
      wr(a);
      chk_wr(a, 1'b0);
    end
    bus.i_wr_enable = 0; bus.i_frame_start = 1; cyc(); bus.i_frame_start = 0;
    chk("sync_pulse", 32'(bus.o_sync_error), 32'd1);
    chk("sync_state", 32'(bus.o_state), 32'd2);
    chk("sync_count", 32'(bus.o_frame_count), 32'd1);
    cyc();
    chk("sync_clr", 32'(bus.o_sync_error), 32'd0);
    frame(0, 1'b0);
    // frame start while PENDING: overrun, write blocked
    bus.i_wr_enable = 1; bus.i_wr_address = 19'd3; bus.i_frame_start = 1;
    cyc();
    bus.i_wr_enable = 0; bus.i_frame_start = 0;
    chk("overrun_pulse", 32'(bus.o_overrun), 32'd1);
    chk("overrun_no_wr", 32'(bus.o_ram_wr_enable), 32'd0);
    chk("overrun_state", 32'(bus.o_state), 32'd3);
    cyc();
    chk("overrun_clr", 32'(bus.o_overrun), 32'd0);
    bus.i_disp_frame_end = 1; cyc(); bus.i_disp_frame_end = 0;
    chk("swap2_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    chk("swap2_count", 32'(bus.o_frame_count), 32'd2);
    chk("swap2_done", 32'(bus.o_frame_done), 32'd1);
    chk("swap2_state", 32'(bus.o_state), 32'd1);
    // last write coincident with display end
    bus.i_frame_start = 1; cyc(); bus.i_frame_start = 0;
    for (int a = 0; a < NP - 1; a++) begin
      wr(a);
      chk_wr(a, 1'b1);
    end
    bus.i_disp_frame_end = 1; wr(NP - 1); bus.i_disp_frame_end = 0; bus.i_wr_enable = 0;
    chk_wr(NP - 1, 1'b1);
    chk("coinc_rd_bank", 32'(bus.o_rd_bank), 32'd1);
    chk("coinc_count", 32'(bus.o_frame_count), 32'd3);
    chk("coinc_done", 32'(bus.o_frame_done), 32'd1);
    chk("coinc_state", 32'(bus.o_state), 32'd1);
    bus.i_frame_start = 1; cyc(); bus.i_frame_start = 0;
    wr(0);
    chk_wr(0, 1'b0);
    frame(1, 1'b0);
    // display end and frame start together: straight to CAPTURE, counter wraps
    bus.i_disp_frame_end = 1; bus.i_frame_start = 1; cyc();
    bus.i_disp_frame_end = 0; bus.i_frame_start = 0;
    chk("both_state", 32'(bus.o_state), 32'd2);
    chk("both_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    chk("both_count_wrap", 32'(bus.o_frame_count), 32'd0);
    chk("both_overrun", 32'(bus.o_overrun), 32'd0);
    chk("both_done", 32'(bus.o_frame_done), 32'd1);
    // asynchronous reset mid-capture
    for (int a = 0; a < 6; a++) begin
      wr(a);
      chk_wr(a, 1'b1);
    end
    bus.i_wr_address = 19'd6; bus.i_wr_data = pix(6);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(bus.o_state), 32'd0);
    chk("arst_ram_en", 32'(bus.o_ram_wr_enable), 32'd0);
    chk("arst_ram_addr", 32'(bus.o_ram_wr_address), 32'd0);
    chk("arst_ram_data", 32'(bus.o_ram_wr_data), 32'd0);
    chk("arst_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    chk("arst_count", 32'(bus.o_frame_count), 32'd0);
    bus.i_capture_en = 0;
    cyc(); cyc();
    chk("arst_hold_en", 32'(bus.o_ram_wr_enable), 32'd0);
    rst = 1'b0; bus.i_wr_enable = 0;
    cyc();
    chk("post_rst_idle", 32'(bus.o_state), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
